// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential array multiplier.
//   state_t : controller states (IDLE, BUSY, DONE)
//   prod_w  : product width for a given operand width
//   clog2   : ceiling log2, used to size the row counter
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pp_row_adder.sv
// pp_row_adder: one combinational ripple row of full-adder cells.
// Ports:
//   pp_row_i    [WIDTH-1:0]  partial-product row (gated multiplicand)
//   acc_slice_i [WIDTH-1:0]  accumulator slice the row is added into
//   carry_i                  carry into bit 0
//   sum_o       [WIDTH-1:0]  sum slice
//   carry_o                  carry out of the top cell
module pp_row_adder
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] pp_row_i,
    input  logic [WIDTH-1:0] acc_slice_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = carry_i;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        assign sum_o[gi]    = pp_row_i[gi] ^ acc_slice_i[gi] ^ carry[gi];
        assign carry[gi+1]  = (pp_row_i[gi] & acc_slice_i[gi])
                            | (carry[gi] & (pp_row_i[gi] ^ acc_slice_i[gi]));
    end

    assign carry_o = carry[WIDTH];

endmodule

// File: rtl/seq_array_multiplier.sv
// seq_array_multiplier: iterative shift-add multiplier, ROWS_PER_CYCLE
// partial-product rows per clock, unsigned or two's-complement per operation.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (accepted only in IDLE)
//   in_a, in_b            multiplicand, multiplier (WIDTH bits)
//   in_signed             1 = two's-complement operands
//   out_valid/out_ready   product handshake (held in DONE)
//   out_product           2*WIDTH-bit product
//   busy                  high while rows are being accumulated
module seq_array_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    out_product,
    output logic                  busy
);

    localparam int PROD_W = prod_w(WIDTH);
    localparam int CNT_W  = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(ROWS_PER_CYCLE);
    // Counter value at the start of the final BUSY cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - ROWS_PER_CYCLE);

    state_t             state_q, state_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               neg_in;

    // Magnitudes stay WIDTH bits: -2^(WIDTH-1) negates to 2^(WIDTH-1),
    // which is representable as an unsigned WIDTH-bit value.
    assign a_abs  = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign b_abs  = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    assign neg_in = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

    // Accumulator layout: upper half collects row sums, lower half starts
    // holding the multiplier magnitude. Each row shifts right by one, so the
    // current multiplier bit is always at bit 0 and the consumed multiplier
    // bits are replaced by finished low product bits.
    logic [PROD_W-1:0] stage_acc [ROWS_PER_CYCLE+1];

    assign stage_acc[0] = acc_q;

    for (genvar gi = 0; gi < ROWS_PER_CYCLE; gi++) begin : g_row
        logic [WIDTH-1:0] pp_row;
        logic [WIDTH-1:0] sum_slice;
        logic             carry_out;

        assign pp_row = a_mag_q & {WIDTH{stage_acc[gi][0]}};

        pp_row_adder #(
            .WIDTH (WIDTH)
        ) u_row (
            .pp_row_i    (pp_row),
            .acc_slice_i (stage_acc[gi][PROD_W-1:WIDTH]),
            .carry_i     (1'b0),
            .sum_o       (sum_slice),
            .carry_o     (carry_out)
        );

        assign stage_acc[gi+1] = {carry_out, sum_slice, stage_acc[gi][WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        a_mag_d   = a_mag_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_mag_d = a_abs;
                    acc_d   = {{WIDTH{1'b0}}, b_abs};
                    neg_d   = neg_in;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy  = 1'b1;
                acc_d = stage_acc[ROWS_PER_CYCLE];
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == CNT_LAST) begin
                    prod_d  = neg_q ? -stage_acc[ROWS_PER_CYCLE]
                                    :  stage_acc[ROWS_PER_CYCLE];
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            prod_q  <= '0;
            a_mag_q <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            a_mag_q <= a_mag_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_product = prod_q;

endmodule
